// File: rtl/sequence_matcher_pkg.sv
// Shared definitions for the memory-game sequence matcher: symbol width,
// the reserved invalid symbol and the controller state encoding.
package sequence_matcher_pkg;

  localparam int SYM_W = 2;

  typedef logic [SYM_W-1:0] sym_t;

  localparam sym_t SYM_INVALID = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    APPEND = 3'd1,
    SHOW   = 3'd2,
    GAP    = 3'd3,
    INPUT  = 3'd4,
    WIN    = 3'd5,
    LOSE   = 3'd6
  } state_e;

  // The generator can emit the reserved code; it is folded onto symbol 0.
  function automatic sym_t sanitize_sym(input sym_t s);
    return (s == SYM_INVALID) ? '0 : s;
  endfunction

endpackage

// File: rtl/sequence_matcher_seq_store.sv
// Sequence register file: one synchronous write port used when a round adds
// a symbol, one combinational read port shared by replay and checking.
module seq_store
  import sequence_matcher_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  sym_t              wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output sym_t              rdata_o
);

  sym_t mem_q [DEPTH];

  // NOTE: no reset on the storage; a slot is always written in the round that
  // first makes it readable, so clearing it would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sequence_matcher.sv
// Memory-game controller: grows a random symbol sequence by one per round,
// replays it with timed show/gap phases, then checks the player's presses.
module sequence_matcher
  import sequence_matcher_pkg::*;
#(
  parameter int MAX_LEN     = 16,
  parameter int LEN_W       = 5,
  parameter int SHOW_CYCLES = 25000000,
  parameter int GAP_CYCLES  = 12500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       rand_in,
  input  logic             btn_valid,
  input  logic [1:0]       btn_code,
  output logic             show_valid,
  output logic [1:0]       show_code,
  output logic [LEN_W-1:0] level,
  output logic             busy,
  output logic             win,
  output logic             lose
);

  localparam int TIMER_MAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;
  localparam int IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [TIMER_W-1:0] SHOW_LAST = TIMER_W'(SHOW_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LAST  = TIMER_W'(GAP_CYCLES - 1);
  localparam logic [LEN_W-1:0]   LEN_MAX   = LEN_W'(MAX_LEN);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic [TIMER_W-1:0] timer_q, timer_d;

  sym_t rd_sym;
  logic last_idx;
  logic sym_match;

  seq_store #(
    .DEPTH  (MAX_LEN),
    .ADDR_W (IDX_W)
  ) u_store (
    .clk     (clk),
    .we_i    (state_q == APPEND),
    .waddr_i (len_q[IDX_W-1:0]),
    .wdata_i (sanitize_sym(rand_in)),
    .raddr_i (idx_q[IDX_W-1:0]),
    .rdata_o (rd_sym)
  );

  assign last_idx  = (idx_q == len_q - LEN_W'(1));
  assign sym_match = (btn_code != SYM_INVALID) && (btn_code == rd_sym);

  // NOTE: state is updated only with non-blocking assignments so every
  // register samples the values from before this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
    end
  end

  // NOTE: every target gets a hold value up front so no path leaves a latch.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    case (state_q)
      IDLE, WIN, LOSE: begin
        if (start) begin
          len_d   = '0;
          state_d = APPEND;
        end
      end
      APPEND: begin
        len_d   = len_q + LEN_W'(1);
        idx_d   = '0;
        state_d = SHOW;
      end
      SHOW: begin
        if (timer_q == SHOW_LAST) state_d = GAP;
        else                      timer_d = timer_q + TIMER_W'(1);
      end
      GAP: begin
        if (timer_q == GAP_LAST) begin
          if (last_idx) begin
            idx_d   = '0;
            state_d = INPUT;
          end else begin
            idx_d   = idx_q + LEN_W'(1);
            state_d = SHOW;
          end
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      INPUT: begin
        // start is deliberately not looked at here: a press always has priority.
        if (btn_valid) begin
          if (!sym_match)              state_d = LOSE;
          else if (!last_idx)          idx_d   = idx_q + LEN_W'(1);
          else if (len_q == LEN_MAX)   state_d = WIN;
          else                         state_d = APPEND;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) timer_d = '0;
  end

  always_comb begin
    show_valid = 1'b0;
    show_code  = '0;
    busy       = 1'b0;
    win        = 1'b0;
    lose       = 1'b0;
    case (state_q)
      APPEND: busy = 1'b1;
      SHOW: begin
        busy       = 1'b1;
        show_valid = 1'b1;
        show_code  = rd_sym;
      end
      GAP:     busy = 1'b1;
      WIN:     win  = 1'b1;
      LOSE:    lose = 1'b1;
      default: ;
    endcase
  end

  assign level = len_q;

endmodule

// File: tb/tb_sequence_matcher.sv
// Self-checking bench for sequence_matcher: vector table, directed multi-cycle
// scenarios and randomized games against a round-level game model.
module tb_sequence_matcher;

  localparam int MAX_LEN     = 3;
  localparam int LEN_W       = 5;
  localparam int SHOW_CYCLES = 4;
  localparam int GAP_CYCLES  = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [1:0]       rand_in;
  logic             btn_valid;
  logic [1:0]       btn_code;
  logic             show_valid;
  logic [1:0]       show_code;
  logic [LEN_W-1:0] level;
  logic             busy;
  logic             win;
  logic             lose;

  int errors = 0;
  int checks = 0;

  // Model: the sequence the player is expected to reproduce.
  logic [1:0] seq_q [$];

  typedef struct {
    logic [1:0] rnd;
    logic [1:0] btn;
    logic [1:0] shown;
    bit         lose;
  } vec_t;

  vec_t vecs [8];

  always #5 clk = ~clk;

  sequence_matcher #(
    .MAX_LEN     (MAX_LEN),
    .LEN_W       (LEN_W),
    .SHOW_CYCLES (SHOW_CYCLES),
    .GAP_CYCLES  (GAP_CYCLES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rand_in    (rand_in),
    .btn_valid  (btn_valid),
    .btn_code   (btn_code),
    .show_valid (show_valid),
    .show_code  (show_code),
    .level      (level),
    .busy       (busy),
    .win        (win),
    .lose       (lose)
  );

  function automatic logic [1:0] model_sym(input logic [1:0] r);
    return (r == 2'd3) ? 2'd0 : r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Packed as {show_valid, show_code, level, busy, win, lose}.
  task automatic expect_status(input string name, input bit sv, input logic [1:0] sc,
                               input int lvl, input bit b, input bit w, input bit l);
    check(name, {21'd0, show_valid, show_code, level, busy, win, lose},
                {21'd0, sv, sc, LEN_W'(lvl), b, w, l});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    start     = 1'b0;
    btn_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic press(input logic [1:0] code);
    btn_valid = 1'b1;
    btn_code  = code;
    tick();
    btn_valid = 1'b0;
  endtask

  // Called on the first SHOW cycle; returns on the first INPUT cycle.
  task automatic replay_check(input string tag, input bit noise);
    for (int i = 0; i < seq_q.size(); i++) begin
      for (int c = 0; c < SHOW_CYCLES; c++) begin
        expect_status({tag, "_show"}, 1'b1, seq_q[i], seq_q.size(), 1'b1, 1'b0, 1'b0);
        if (noise) begin
          btn_valid = 1'($urandom_range(0, 1));
          btn_code  = 2'($urandom_range(0, 3));
        end
        tick();
      end
      for (int c = 0; c < GAP_CYCLES; c++) begin
        expect_status({tag, "_gap"}, 1'b0, 2'd0, seq_q.size(), 1'b1, 1'b0, 1'b0);
        if (noise) begin
          btn_valid = 1'($urandom_range(0, 1));
          btn_code  = 2'($urandom_range(0, 3));
        end
        tick();
      end
    end
    btn_valid = 1'b0;
    expect_status({tag, "_input"}, 1'b0, 2'd0, seq_q.size(), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic new_game(input logic [1:0] r, input logic [1:0] sym, input bit with_btn,
                          input bit noise, input string tag);
    start     = 1'b1;
    rand_in   = r;
    btn_valid = with_btn;
    btn_code  = 2'($urandom_range(0, 3));
    tick();
    start     = 1'b0;
    btn_valid = 1'b0;
    expect_status({tag, "_append"}, 1'b0, 2'd0, 0, 1'b1, 1'b0, 1'b0);
    seq_q.delete();
    seq_q.push_back(sym);
    tick();
    replay_check(tag, noise);
  endtask

  // Called on the APPEND cycle that follows a completed round.
  task automatic next_round(input logic [1:0] sym, input string tag, input bit noise);
    expect_status({tag, "_append"}, 1'b0, 2'd0, seq_q.size(), 1'b1, 1'b0, 1'b0);
    seq_q.push_back(sym);
    tick();
    replay_check(tag, noise);
  endtask

  initial begin
    logic [1:0] r;
    logic [1:0] code;
    bit         wrong;
    bit         done;
    int         n;

    rand_in  = 2'd0;
    btn_code = 2'd0;
    do_reset();
    expect_status("reset", 1'b0, 2'd0, 0, 1'b0, 1'b0, 1'b0);

    // Full game to a win: rounds 2 / 2,1 / 2,1,0.
    new_game(2'd2, 2'd2, 1'b0, 1'b0, "plan_r1");
    rand_in = 2'd1;
    press(2'd2);
    next_round(2'd1, "plan_r2", 1'b0);
    rand_in = 2'd0;
    press(2'd2);
    expect_status("plan_r2_mid", 1'b0, 2'd0, 2, 1'b0, 1'b0, 1'b0);
    press(2'd1);
    next_round(2'd0, "plan_r3", 1'b0);
    press(2'd2);
    press(2'd1);
    press(2'd0);
    expect_status("plan_win", 1'b0, 2'd0, 3, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      btn_valid = 1'($urandom_range(0, 1));
      btn_code  = 2'($urandom_range(0, 3));
      tick();
      expect_status("win_hold", 1'b0, 2'd0, 3, 1'b0, 1'b1, 1'b0);
    end

    // start together with btn_valid in WIN: start wins.
    new_game(2'd1, 2'd1, 1'b1, 1'b0, "win_restart");

    // Level-2 lose: sequence 1,2, player enters 1 then 0.
    rand_in = 2'd2;
    press(2'd1);
    next_round(2'd2, "lose_r2", 1'b0);
    press(2'd1);
    press(2'd0);
    expect_status("lose_flag", 1'b0, 2'd0, 2, 1'b0, 1'b0, 1'b1);
    press(2'd1);
    press(2'd2);
    tick();
    expect_status("lose_hold", 1'b0, 2'd0, 2, 1'b0, 1'b0, 1'b1);

    // start alone in INPUT is ignored; start with a press lets the press through.
    new_game(2'd0, 2'd0, 1'b0, 1'b0, "sel");
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_status("start_in_input", 1'b0, 2'd0, 1, 1'b0, 1'b0, 1'b0);
    start     = 1'b1;
    btn_valid = 1'b1;
    btn_code  = 2'd0;
    rand_in   = 2'd3;
    tick();
    start     = 1'b0;
    btn_valid = 1'b0;
    next_round(model_sym(2'd3), "start_btn", 1'b1);

    // Reset during SHOW aborts immediately.
    rand_in = 2'd2;
    press(2'd0);
    press(2'd0);
    tick();
    tick();
    expect_status("pre_reset_show", 1'b1, 2'd0, 3, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_status("mid_reset", 1'b0, 2'd0, 0, 1'b0, 1'b0, 1'b0);
    tick();
    expect_status("idle_after_reset", 1'b0, 2'd0, 0, 1'b0, 1'b0, 1'b0);

    // Single-press table at level 1.
    vecs[0] = '{2'd0, 2'd0, 2'd0, 1'b0};
    vecs[1] = '{2'd1, 2'd1, 2'd1, 1'b0};
    vecs[2] = '{2'd2, 2'd2, 2'd2, 1'b0};
    vecs[3] = '{2'd3, 2'd0, 2'd0, 1'b0};
    vecs[4] = '{2'd3, 2'd3, 2'd0, 1'b1};
    vecs[5] = '{2'd2, 2'd1, 2'd2, 1'b1};
    vecs[6] = '{2'd0, 2'd3, 2'd0, 1'b1};
    vecs[7] = '{2'd1, 2'd2, 2'd1, 1'b1};
    for (int k = 0; k < 8; k++) begin
      do_reset();
      new_game(vecs[k].rnd, vecs[k].shown, 1'b0, 1'b1, $sformatf("vec%0d", k));
      rand_in = 2'd1;
      press(vecs[k].btn);
      expect_status($sformatf("vec%0d_press", k), 1'b0, 2'd0, 1,
                    !vecs[k].lose, 1'b0, vecs[k].lose);
    end

    // Randomized games against the round-level model.
    do_reset();
    for (int g = 0; g < 30; g++) begin
      r = 2'($urandom_range(0, 3));
      new_game(r, model_sym(r), 1'($urandom_range(0, 1)), 1'b1, "rnd_g");
      done = 1'b0;
      while (!done) begin
        n = seq_q.size();
        for (int i = 0; i < n && !done; i++) begin
          repeat ($urandom_range(0, 2)) begin
            tick();
            expect_status("rnd_wait", 1'b0, 2'd0, n, 1'b0, 1'b0, 1'b0);
          end
          wrong = ($urandom_range(0, 7) == 0);
          code  = seq_q[i];
          if (wrong) begin
            do code = 2'($urandom_range(0, 3)); while (code == seq_q[i]);
          end
          r       = 2'($urandom_range(0, 3));
          rand_in = r;
          press(code);
          if (wrong) begin
            expect_status("rnd_lose", 1'b0, 2'd0, n, 1'b0, 1'b0, 1'b1);
            done = 1'b1;
          end else if (i == n - 1) begin
            if (n == MAX_LEN) begin
              expect_status("rnd_win", 1'b0, 2'd0, n, 1'b0, 1'b1, 1'b0);
              done = 1'b1;
            end else begin
              next_round(model_sym(r), "rnd_r", 1'b1);
            end
          end else begin
            expect_status("rnd_next", 1'b0, 2'd0, n, 1'b0, 1'b0, 1'b0);
          end
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sequence_matcher.md
Name: sequence_matcher

Overview:
- Consumer of the 2-bit random stream (values 0..2) that the game's random number generator produces.
- Each round it appends one random symbol to a stored sequence, replays the whole sequence to the display/LED driver, then checks the player's button presses against it.
- Sits between the random number generator, the debounced button decoder and the display driver in the game top level.

Parameters:
- MAX_LEN, 16, maximum sequence length; reaching it and matching it in full is a win.
- LEN_W, 5, width of the length/level counter; must satisfy 2^LEN_W > MAX_LEN.
- SHOW_CYCLES, 25000000, cycles each symbol is displayed.
- GAP_CYCLES, 12500000, blank cycles between displayed symbols.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a new game. Accepted in IDLE, WIN and LOSE only.
- rand_in  in  2  random symbol, sampled only in APPEND; value 3 is treated as 0.
- btn_valid  in  1  single-cycle pulse; player pressed a button.
- btn_code  in  2  button symbol 0..2, qualified by btn_valid; 3 is always a mismatch.
- show_valid  out  1  high while a symbol is being displayed.
- show_code  out  2  symbol being displayed; 0 when show_valid is low.
- level  out  LEN_W  current sequence length.
- busy  out  1  high in APPEND, SHOW and GAP (player input is ignored).
- win  out  1  high while in WIN.
- lose  out  1  high while in LOSE.

Behaviour:
- Reset (sampled at posedge while high): state=IDLE, len=0, idx=0, timer=0, all outputs 0. Memory contents are don't-care. Reset mid-game aborts immediately.
- Storage is MAX_LEN x 2-bit registers, written only in APPEND.
- IDLE: on start, len<=0 and go to APPEND.
- APPEND (1 cycle):
  - mem[len]<=(rand_in==3 ? 0 : rand_in); len<=len+1; idx<=0; timer<=0; go to SHOW.
  - level reflects the new len from the cycle after APPEND.
- SHOW:
  - show_valid=1, show_code=mem[idx]; timer counts.
  - After exactly SHOW_CYCLES cycles in SHOW, go to GAP with timer<=0.
- GAP:
  - show_valid=0.
  - After GAP_CYCLES cycles: if idx==len-1 go to INPUT with idx<=0; else idx<=idx+1 and return to SHOW.
- INPUT: the only state that responds to btn_valid; btn_valid is ignored in every other state.
  - btn_valid and btn_code==mem[idx]:
    - idx==len-1 and len==MAX_LEN: go to WIN.
    - idx==len-1 and len<MAX_LEN: go to APPEND.
    - otherwise: idx<=idx+1.
  - btn_valid and mismatch (including code 3): go to LOSE.
  - Round-trip latency: the state change is visible the cycle after the btn_valid cycle.
- WIN / LOSE: the flag is held and level is held. On start: len<=0 and go to APPEND.
- Simultaneous start and btn_valid in INPUT: start is ignored and btn_valid is processed.
- start in IDLE, WIN or LOSE with btn_valid the same cycle: start wins and btn_valid is dropped.
- Timer width is clog2(max(SHOW_CYCLES, GAP_CYCLES)). The timer never wraps; it is cleared on every state entry.
- One button press is consumed per btn_valid pulse. No input timeout.

Decomposition:
- Shared game package holds:
  - state encoding constants: IDLE, APPEND, SHOW, GAP, INPUT, WIN, LOSE (3-bit).
  - symbol width constant SYM_W=2.
  - invalid-symbol constant 2'b11.
- One natural sub-module: seq_store. It is the MAX_LEN x SYM_W register file with a synchronous write port and an asynchronous read by index, shared between the replay and check paths.
- The FSM, timer and counters stay in sequence_matcher.

Test Plan (sim with SHOW_CYCLES=4, GAP_CYCLES=2, MAX_LEN=3):
- Reset, then start with rand_in=2 → APPEND; show_valid high exactly 4 cycles with show_code=2; 2 blank cycles; level=1; busy falls on entering INPUT.
- Round 1 btn 2 → APPEND samples rand_in=1; replay shows 2 then 1 (4 on / 2 off each); level=2.
- Inputs 2,1 then round 3 (rand_in=0) inputs 2,1,0 → win=1, level=3, lose=0; win held until start.
- Level 2 inputs 2 then 0 → lose=1 the cycle after the bad press; show_valid stays 0; further btn_valid ignored; level=2.
- rand_in=3 at APPEND → stored and displayed as 0. btn_code=3 in INPUT → lose. btn_valid during SHOW/GAP → no effect on idx or state.
- Reset asserted mid-SHOW → next cycle state IDLE, show_valid=0, level=0. start asserted together with btn_valid in INPUT → start ignored.
